// File: rtl/perm_sched_pkg.sv
// perm_sched_pkg: shared state encoding and permutation codes for the scheduler
package perm_sched_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DONE} state_t;
  localparam logic [1:0] PERM_IN = 2'd0;
  localparam logic [1:0] PERM_MID = 2'd1;
  localparam logic [1:0] PERM_OUT = 2'd2;
  localparam logic [1:0] PERM_INV_IN = 2'd3;
endpackage

// File: rtl/permutation_scheduler.sv
// permutation_scheduler: sequences permutation passes (issue, latency wait, write-back) for one transform
module permutation_scheduler
  import perm_sched_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int PERM_LAT = 1,
  parameter int STAGE_W = $clog2(NUM_STAGES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cfg_inverse,
  input  logic               wb_stall,
  output logic [1:0]         perm_select,
  output logic               perm_valid,
  output logic               wb_en,
  output logic [STAGE_W-1:0] stage_idx,
  output logic               busy,
  output logic               done
);
  state_t state, state_nx;
  logic [STAGE_W-1:0] stage_nx, stage_inc;
  logic [1:0] sel_nx;
  logic inv, inv_nx, last;
  logic [3:0] cnt, cnt_nx;
  function automatic logic [1:0] pass_code(input logic [STAGE_W-1:0] s, input logic iv);
    return (s == '0) ? (iv ? PERM_INV_IN : PERM_IN) :
           (s == STAGE_W'(NUM_STAGES - 1)) ? (iv ? PERM_IN : PERM_OUT) : PERM_MID;
  endfunction
  assign stage_inc = stage_idx + 1'b1;
  assign last = stage_idx == STAGE_W'(NUM_STAGES - 1);
  assign perm_valid = state == ISSUE;
  assign wb_en = state == WB && !wb_stall;
  assign busy = state inside {ISSUE, WAIT, WB};
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stage_idx <= '0;
      perm_select <= PERM_IN;
      inv <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      stage_idx <= stage_nx;
      perm_select <= sel_nx;
      inv <= inv_nx;
      cnt <= cnt_nx;
    end
  // perm_select is loaded on entry to ISSUE so it is stable for the whole pass
  always_comb begin
    state_nx = state;
    stage_nx = stage_idx;
    sel_nx = perm_select;
    inv_nx = inv;
    cnt_nx = cnt;
    case (state)
      IDLE: if (start) begin
        state_nx = ISSUE;
        inv_nx = cfg_inverse;
        stage_nx = '0;
        sel_nx = pass_code('0, cfg_inverse);
      end
      ISSUE: begin
        state_nx = WAIT;
        cnt_nx = 4'(PERM_LAT - 1);
      end
      WAIT: begin
        state_nx = cnt == '0 ? WB : WAIT;
        cnt_nx = cnt - 4'd1;
      end
      WB: if (!wb_stall) begin
        state_nx = last ? DONE : ISSUE;
        stage_nx = last ? stage_idx : stage_inc;
        sel_nx = last ? perm_select : pass_code(stage_inc, inv);
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_permutation_scheduler.sv
// tb_permutation_scheduler: two configurations driven by shared stimulus, checked against a pass-level schedule model
module tb_permutation_scheduler;
  localparam int NMAX = 1024;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_inverse = 1'b0, wb_stall = 1'b0;
  logic [1:0] a_sel, b_sel;
  logic [1:0] a_stage;
  logic [0:0] b_stage;
  logic a_pv, a_wb, a_busy, a_done, b_pv, b_wb, b_busy, b_done;
  int errors = 0, checks = 0;
  bit st[NMAX], cf[NMAX], sl[NMAX];
  int ex[2][6][NMAX];
  int ob[2][6][NMAX];
  string fn[6] = '{"pv", "wb", "done", "busy", "sel", "stage"};
  always #5 clk = ~clk;
  permutation_scheduler #(.NUM_STAGES(4), .PERM_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_inverse(cfg_inverse), .wb_stall(wb_stall),
    .perm_select(a_sel), .perm_valid(a_pv), .wb_en(a_wb), .stage_idx(a_stage), .busy(a_busy), .done(a_done));
  permutation_scheduler #(.NUM_STAGES(2), .PERM_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_inverse(cfg_inverse), .wb_stall(wb_stall),
    .perm_select(b_sel), .perm_valid(b_pv), .wb_en(b_wb), .stage_idx(b_stage), .busy(b_busy), .done(b_done));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int cur(input int d, input int f);
    case (f)
      0: return d ? int'(b_pv) : int'(a_pv);
      1: return d ? int'(b_wb) : int'(a_wb);
      2: return d ? int'(b_done) : int'(a_done);
      3: return d ? int'(b_busy) : int'(a_busy);
      4: return d ? int'(b_sel) : int'(a_sel);
      default: return d ? int'(b_stage) : int'(a_stage);
    endcase
  endfunction
  // Schedule per pass: issue, PERM_LAT wait cycles, then write-back on the first unstalled cycle
  task automatic model(input int d, input int n, input int l, input int nc);
    int c = 0, t, w, code, sel = 0, stg = 0;
    bit inv;
    for (int k = 0; k < NMAX; k++) for (int f = 0; f < 6; f++) ex[d][f][k] = 0;
    while (c < nc) begin
      ex[d][4][c] = sel;
      ex[d][5][c] = stg;
      if (st[c]) begin
        inv = cf[c];
        t = c + 1;
        for (int p = 0; p < n; p++) begin
          w = t + l + 1;
          while (w < NMAX - 2 && sl[w]) w++;
          code = p == 0 ? (inv ? 3 : 0) : p == n - 1 ? (inv ? 0 : 2) : 1;
          for (int k = t; k <= w; k++) begin
            ex[d][3][k] = 1;
            ex[d][4][k] = code;
            ex[d][5][k] = p;
          end
          ex[d][0][t] = 1;
          ex[d][1][w] = 1;
          t = w + 1;
          sel = code;
          stg = p;
        end
        ex[d][2][t] = 1;
        ex[d][4][t] = sel;
        ex[d][5][t] = stg;
        c = t + 1;
      end else c++;
    end
  endtask
  task automatic clear_stim();
    for (int k = 0; k < NMAX; k++) begin
      st[k] = 0;
      cf[k] = 0;
      sl[k] = 0;
    end
  endtask
  task automatic run(input int nc);
    model(0, 4, 2, nc);
    model(1, 2, 1, nc);
    rst_n = 1'b0;
    start = 1'b0;
    cfg_inverse = 1'b0;
    wb_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) for (int f = 0; f < 6; f++) check($sformatf("rst_%s%0d", fn[f], d), cur(d, f), 0);
    rst_n = 1'b1;
    for (int c = 0; c < nc; c++) begin
      start = st[c];
      cfg_inverse = cf[c];
      wb_stall = sl[c];
      @(negedge clk);
      for (int d = 0; d < 2; d++) for (int f = 0; f < 6; f++) begin
        ob[d][f][c] = cur(d, f);
        check($sformatf("%s%0d_c%0d", fn[f], d, c), ob[d][f][c], ex[d][f][c]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int pvc[4] = '{1, 5, 9, 13};
    int fsel[4] = '{0, 1, 1, 2};
    int isel[4] = '{3, 1, 1, 0};
    clear_stim();
    st[0] = 1;
    run(30);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fwd_pv_at%0d", pvc[i]), ob[0][0][pvc[i]], 1);
      check($sformatf("fwd_wb_at%0d", pvc[i] + 3), ob[0][1][pvc[i] + 3], 1);
      check($sformatf("fwd_sel_pass%0d", i), ob[0][4][pvc[i]], fsel[i]);
    end
    check("fwd_done_at17", ob[0][2][17], 1);
    check("n2_done_at7", ob[1][2][7], 1);
    check("n2_sel_pass0", ob[1][4][1], 0);
    check("n2_sel_pass1", ob[1][4][4], 2);
    clear_stim();
    st[0] = 1;
    for (int k = 0; k < 30; k++) cf[k] = (k % 2 == 0);
    run(30);
    for (int i = 0; i < 4; i++) check($sformatf("inv_sel_pass%0d", i), ob[0][4][pvc[i]], isel[i]);
    clear_stim();
    st[0] = 1;
    for (int k = 8; k <= 10; k++) sl[k] = 1;
    run(30);
    check("stall_wb_at8", ob[0][1][8], 0);
    check("stall_wb_at11", ob[0][1][11], 1);
    check("stall_done_at20", ob[0][2][20], 1);
    clear_stim();
    for (int k = 0; k < 40; k++) st[k] = 1;
    run(40);
    check("hold_pv_at18", ob[0][0][18], 0);
    check("hold_pv_at19", ob[0][0][19], 1);
    clear_stim();
    st[0] = 1;
    run(11);
    check("mid_busy", int'(a_busy), 1);
    check("mid_stage", int'(a_stage), 2);
    rst_n = 1'b0;
    #1;
    for (int f = 0; f < 6; f++) check($sformatf("async_rst_%s", fn[f]), cur(0, f), 0);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_pv", int'(a_pv), 1);
    check("restart_stage", int'(a_stage), 0);
    check("restart_sel", int'(a_sel), 0);
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      for (int k = 0; k < NMAX; k++) begin
        st[k] = ($urandom_range(0, 3) == 0);
        cf[k] = 1'($urandom);
        sl[k] = ($urandom_range(0, 2) == 0);
      end
      run(300);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
